// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants; no logic, zero latency, no backpressure.
// Count width, default wrap point, seconds-per-minute adjust step and FSM state encoding.
package stopwatch_pkg;

  localparam int COUNT_W       = 13;
  localparam int MAX_COUNT_DEF = 5999;
  localparam int SEC_PER_MIN   = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/stopwatch_counter_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce counter, rising-edge press pulse.
// Press pulse lands 2 + DEBOUNCE_CYCLES cycles after a clean raw edge; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    // Any sample agreeing with the accepted level restarts the stability window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: debounced buttons drive an IDLE/RUN/PAUSE FSM gating a 1 Hz divider and seconds count.
// Outputs registered, tick and count update together one cycle after divider terminal; STOPWATCH_ADJUST_EN adds btn_adj.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_COUNT       = MAX_COUNT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_pause,
  input  logic               btn_clear,
  input  logic               btn_adj,
  input  logic               adj_sel,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               tick_1hz
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               running_q, running_d;
  logic               tick_q, tick_d;
  logic               pause_press, clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_pause), .press(pause_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .press(clear_press)
  );

`ifdef STOPWATCH_ADJUST_EN
  logic             adj_press;
  logic [COUNT_W:0] adj_sum;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_adj (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_adj), .press(adj_press)
  );

  // Step is at most one minute, so a single conditional subtract completes the modulo.
  always_comb begin
    adj_sum = {1'b0, count_q} + (adj_sel ? (COUNT_W+1)'(SEC_PER_MIN) : (COUNT_W+1)'(1));
    if (adj_sum > (COUNT_W+1)'(MAX_COUNT)) begin
      adj_sum = adj_sum - (COUNT_W+1)'(MAX_COUNT + 1);
    end
  end
`else
  logic unused_adj;
  assign unused_adj = btn_adj ^ adj_sel;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;

    if (state_q == RUN) begin
      if (div_q == DIV_W'(CLK_HZ - 1)) begin
        div_d   = '0;
        tick_d  = 1'b1;
        count_d = (count_q == COUNT_W'(MAX_COUNT)) ? '0 : count_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Priority: clear, then pause, then adjust; a same-cycle tick survives a pause.
    if (clear_press) begin
      state_d = IDLE;
      div_d   = '0;
      count_d = '0;
      tick_d  = 1'b0;
    end else if (pause_press) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
`ifdef STOPWATCH_ADJUST_EN
    end else if (adj_press && (state_q != RUN)) begin
      count_d = adj_sum[COUNT_W-1:0];
      state_d = PAUSE;
`endif
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      count_q   <= count_d;
      running_q <= running_d;
      tick_q    <= tick_d;
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: two stopwatch instances (MAX_COUNT 5999 and 5) sharing buttons, CLK_HZ=10, DEBOUNCE_CYCLES=4.
// Schedule index k: stimulus raised at k takes effect on outputs sampled at k+7.
module tb_stopwatch_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_pause = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_adj = 1'b0;
  logic        adj_sel = 1'b0;
  logic [12:0] count_m, count_w;
  logic        running_m, running_w, tick_m, tick_w;

  int n_cmp = 0;
  int n_fail = 0;
  int m_cnt = 0;
  int w_cnt = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4), .MAX_COUNT(5999)) u_main (
    .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .btn_adj(btn_adj), .adj_sel(adj_sel),
    .count(count_m), .running(running_m), .tick_1hz(tick_m)
  );

  stopwatch_counter #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4), .MAX_COUNT(5)) u_wrap (
    .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .btn_adj(btn_adj), .adj_sel(adj_sel),
    .count(count_w), .running(running_w), .tick_1hz(tick_w)
  );

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  function automatic logic pause_lvl(input int k);
    return in_rng(k, -7, 2) || in_rng(k, 28, 37) || in_rng(k, 50, 59) ||
           in_rng(k, 86, 87) || in_rng(k, 91, 92) || in_rng(k, 96, 97) ||
           in_rng(k, 106, 115) || in_rng(k, 141, 150) || in_rng(k, 220, 229) ||
           in_rng(k, 241, 250);
  endfunction

  function automatic logic clear_lvl(input int k);
    return in_rng(k, 126, 135) || in_rng(k, 220, 229);
  endfunction

  function automatic logic run_exp(input int k);
    return in_rng(k, 0, 34) || in_rng(k, 57, 112) || in_rng(k, 148, 226) || (k >= 248);
  endfunction

  function automatic logic tick_exp(input int k);
    return (k == 10) || (k == 20) || (k == 30) ||
           (in_rng(k, 62, 112) && ((k - 62) % 10 == 0)) ||
           (in_rng(k, 158, 218) && ((k - 158) % 10 == 0)) ||
           (k == 258);
  endfunction

  task automatic press_adj(input logic sel);
    adj_sel = sel;
    btn_adj = 1'b1;
    repeat (10) @(negedge clk);
    btn_adj = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Run, pause/resume, wrap, glitch rejection, clear, then clear+pause together.
    for (int k = -7; k <= 262; k++) begin
      @(negedge clk);
      if (k == 133 || k == 227) begin
        m_cnt = 0;
        w_cnt = 0;
      end else if (tick_exp(k)) begin
        m_cnt = m_cnt + 1;
        w_cnt = (w_cnt == 5) ? 0 : w_cnt + 1;
      end
      chk("main_running", k, 16'(running_m), 16'(run_exp(k)));
      chk("main_tick",    k, 16'(tick_m),    16'(tick_exp(k)));
      chk("main_count",   k, 16'(count_m),   16'(m_cnt));
      chk("wrap_running", k, 16'(running_w), 16'(run_exp(k)));
      chk("wrap_tick",    k, 16'(tick_w),    16'(tick_exp(k)));
      chk("wrap_count",   k, 16'(count_w),   16'(w_cnt));
      btn_pause = pause_lvl(k);
      btn_clear = clear_lvl(k);
    end

    // Asynchronous reset in the middle of a running second.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count",   0, 16'(count_m),   16'd0);
    chk("rst_running", 0, 16'(running_m), 16'd0);
    chk("rst_tick",    0, 16'(tick_m),    16'd0);
    chk("rst_wcount",  0, 16'(count_w),   16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("post_rst_count",   j, 16'(count_m),   16'd0);
      chk("post_rst_running", j, 16'(running_m), 16'd0);
    end

`ifdef STOPWATCH_ADJUST_EN
    // 99 minute steps then 50 second steps from IDLE reach 5990 in PAUSE.
    for (int i = 0; i < 99; i++) press_adj(1'b1);
    for (int i = 0; i < 50; i++) press_adj(1'b0);
    chk("adj_5990",        0, 16'(count_m),   16'd5990);
    chk("adj_running",     0, 16'(running_m), 16'd0);
    press_adj(1'b1);
    chk("adj_wrap_50",     0, 16'(count_m),   16'd50);
    chk("adj_wrap_run",    0, 16'(running_m), 16'd0);
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) @(negedge clk);
      chk("adj_run_running", j, 16'(running_m), 16'(j >= 7));
      chk("adj_run_count",   j, 16'(count_m),   (j < 17) ? 16'd50 : ((j < 27) ? 16'd51 : 16'd52));
      btn_pause = (j <= 9);
      adj_sel   = 1'b0;
      btn_adj   = (j >= 8) && (j <= 17);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
